// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word addresses to a
// one-cycle-latency instruction memory, buffers returned words in a small
// FIFO and hands {pc, instr, fault} to decode over valid/ready.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd1,
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;

    // Single in-flight fetch: the address issued last cycle, awaiting imem_data.
    logic              inflight_valid_q;
    logic [31:0]       inflight_pc_q;
    logic              inflight_fault_q;

    logic [31:0]       buf_instr_q [BUF_DEPTH];
    logic [31:0]       buf_pc_q    [BUF_DEPTH];
    logic              buf_fault_q [BUF_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              permitted;
    logic              pc_in_range;
    logic [31:0]       occupancy;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = buf_instr_q[rd_ptr_q];
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign out_fault = buf_fault_q[rd_ptr_q];

    // Handshake, space accounting and FSM next state.
    always_comb begin
        pop         = out_valid & out_ready;
        // A redirect drops the returning word instead of buffering it.
        push        = inflight_valid_q & ~redirect_valid;
        // Entries that will be occupied once the in-flight word lands.
        occupancy   = 32'(count_q) + 32'(inflight_valid_q) - 32'(pop);
        permitted   = occupancy < BUF_DEPTH;
        pc_in_range = fetch_pc_q < MEM_SIZE;

        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_en && pc_in_range) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!fetch_en) begin
                    state_d = StIdle;
                end else if (permitted) begin
                    issue = 1'b1;
                    // The out-of-range address goes out exactly once, then fetching stops.
                    if (!pc_in_range) begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect_valid) begin
            issue   = 1'b0;
            state_d = fetch_en ? StRun : StIdle;
        end
    end

    // Fetch PC and FIFO pointer/count next state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state: FSM, fetch PC, in-flight tracker, FIFO pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= StIdle;
            fetch_pc_q       <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_fault_q <= 1'b0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= issue;
            inflight_pc_q    <= fetch_pc_q;
            inflight_fault_q <= ~pc_in_range;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
                buf_fault_q[i] <= 1'b0;
            end
        end else if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_data;
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
            buf_fault_q[wr_ptr_q] <= inflight_fault_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the expected word stream is
// queued whenever reset or a redirect sets a new start PC, and every word
// decode accepts is popped and compared.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];

    instruction_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .PC_STEP   (32'd1),
        .MEM_SIZE  (MEM_SIZE),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: mem[i] = i + 0x100, out of range reads DEADBEEF.
    always @(posedge clk) begin
        imem_data <= (imem_addr < MEM_SIZE) ? imem_addr + 32'h100 : 32'hDEADBEEF;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected stream from a start PC, ending with the first out-of-range word.
    function automatic void sb_fill(input logic [31:0] start);
        logic [31:0] pc;
        exp_t        e;
        pc = start;
        sb_q.delete();
        for (int i = 0; i < 200; i++) begin
            e.pc    = pc;
            e.fault = (pc >= MEM_SIZE);
            e.instr = e.fault ? 32'hDEADBEEF : pc + 32'h100;
            sb_q.push_back(e);
            if (e.fault) break;
            pc = pc + 32'd1;
        end
    endfunction

    // Scoreboard: compare each accepted word, then restart the stream on reset/redirect.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            check_val("sb_have", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("sb_pc", out_pc, e.pc);
                check_val("sb_instr", out_instr, e.instr);
                check_val("sb_fault", out_fault, e.fault);
            end
        end
        if (reset !== 1'b1) begin
            sb_fill(RESET_PC);
        end else if (redirect_valid) begin
            sb_fill(redirect_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, out_valid, 1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) tick();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_pc", out_pc, 0);
        check_val("rst_instr", out_instr, 0);
        check_val("rst_fault", out_fault, 0);
        check_val("rst_addr", imem_addr, RESET_PC);
        reset = 1'b1;

        // Streaming from reset: one word per cycle with no gaps.
        wait_valid("t1_first", 10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("t1_nogap", out_valid, 1);
        end

        // Decode stall: head and fetch address hold, FIFO fills.
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t2_valid", out_valid, 1);
            check_val("t2_head", out_pc, sb_q[0].pc);
            check_val("t2_addr", imem_addr, sb_q[0].pc + 32'd2);
        end
        tick();
        out_ready = 1'b1;
        repeat (6) tick();

        // Redirect while the FIFO is full.
        out_ready = 1'b0;
        repeat (4) tick();
        redirect_to(32'h40);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("t3_flush", out_valid, 0);
        check_val("t3_addr", imem_addr, 32'h40);
        @(negedge clk);
        check_val("t3_lat1", out_valid, 0);
        @(negedge clk);
        check_val("t3_lat2", out_valid, 1);
        check_val("t3_pc", out_pc, 32'h40);
        repeat (5) tick();

        // Redirect and pop in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        @(negedge clk);
        check_val("t6_popvalid", out_valid, 1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_val("t6_empty", out_valid, 0);
        wait_valid("t6_resume", 10);
        repeat (6) tick();

        // fetch_en low drains the FIFO; raising it resumes the stream.
        fetch_en = 1'b0;
        repeat (6) tick();
        check_val("en_drained", out_valid, 0);
        fetch_en = 1'b1;
        wait_valid("en_resume", 10);
        repeat (6) tick();

        // Out-of-range fetch at the top of memory.
        redirect_to(32'd1022);
        repeat (14) tick();
        check_val("t4_addr", imem_addr, 32'd1025);
        check_val("t4_quiet", out_valid, 0);
        check_val("t4_drained", sb_q.size(), 0);
        redirect_to(32'd0);
        wait_valid("t4_recover", 10);
        repeat (6) tick();

        // Reset pulse mid-stream.
        reset = 1'b0;
        tick();
        check_val("t5_valid", out_valid, 0);
        check_val("t5_pc", out_pc, 0);
        check_val("t5_addr", imem_addr, RESET_PC);
        reset = 1'b1;
        wait_valid("t5_restart", 10);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
